// File: rtl/dcp_req_tracker_if.sv
// Shared DCP request types and the bundled handshake interface of dcp_req_tracker.
//
// dcp_pkg            : field types for requests, responses and completions
// dcp_req_tracker_if : request, tagged-request, response and completion channels
//   modport slave  - tracker side (accepts req/resp, drives out/cmp)
//   modport master - environment side (drives req/resp, accepts out/cmp)
//
// `DCP_MSHRID_WIDTH sets the width of the MSHR id (defaults to 3 here).

`ifndef DCP_MSHRID_WIDTH
`define DCP_MSHRID_WIDTH 3
`endif

package dcp_pkg;
    typedef logic [4:0]                     req_type_t;
    typedef logic [39:0]                    paddr_t;
    typedef logic [2:0]                     size_t;
    typedef logic [5:0]                     homeid_t;
    typedef logic [7:0]                     write_mask_t;
    typedef logic [63:0]                    data_t;
    typedef logic [`DCP_MSHRID_WIDTH-1:0]   mshrid_t;
endpackage

interface dcp_req_tracker_if;
    import dcp_pkg::*;

    logic           req_val;
    logic           req_rdy;
    req_type_t      req_type;
    paddr_t         req_paddr;
    size_t          req_size;
    homeid_t        req_homeid;
    write_mask_t    req_wmask;
    data_t          req_data;

    logic           out_val;
    logic           out_rdy;
    req_type_t      out_type;
    paddr_t         out_paddr;
    size_t          out_size;
    homeid_t        out_homeid;
    write_mask_t    out_wmask;
    data_t          out_data;
    mshrid_t        out_mshrid;

    logic           resp_val;
    logic           resp_rdy;
    mshrid_t        resp_mshrid;
    data_t          resp_data;

    logic           cmp_val;
    logic           cmp_rdy;
    paddr_t         cmp_paddr;
    size_t          cmp_size;
    data_t          cmp_data;

    modport slave (
        input  req_val, req_type, req_paddr, req_size, req_homeid, req_wmask, req_data,
        output req_rdy,
        output out_val, out_type, out_paddr, out_size, out_homeid, out_wmask, out_data, out_mshrid,
        input  out_rdy,
        input  resp_val, resp_mshrid, resp_data,
        output resp_rdy,
        output cmp_val, cmp_paddr, cmp_size, cmp_data,
        input  cmp_rdy
    );

    modport master (
        output req_val, req_type, req_paddr, req_size, req_homeid, req_wmask, req_data,
        input  req_rdy,
        input  out_val, out_type, out_paddr, out_size, out_homeid, out_wmask, out_data, out_mshrid,
        output out_rdy,
        output resp_val, resp_mshrid, resp_data,
        input  resp_rdy,
        input  cmp_val, cmp_paddr, cmp_size, cmp_data,
        output cmp_rdy
    );
endinterface

// File: rtl/dcp_req_tracker.sv
// DCP request tracker: allocates an MSHR id per core request, forwards the tagged
// request downstream, matches responses by id and returns a completion carrying the
// original paddr/size. The entry is freed when the completion is accepted.
//
// Ports
//   clk_i    : clock, rising edge
//   reset_i  : synchronous active-high reset
//   bus      : dcp_req_tracker_if.slave (req / out / resp / cmp channels)
//   busy_o   : registered, some entry is not FREE
//   err_o    : one-cycle pulse, a response to a FREE/DONE/out-of-range id was dropped
// Optional (`ifdef DCP_TRACKER_STATS_EN):
//   stat_req_cnt_o, stat_err_cnt_o, stat_max_outst_o
//
// Entry states
//   state     | meaning
//   ST_FREE   | unallocated, may be picked by the next request
//   ST_ISSUED | request forwarded, waiting for its response
//   ST_DONE   | response held in the completion register, waiting for cmp handshake

module dcp_req_tracker
    import dcp_pkg::*;
#(
    parameter int NUM_MSHR = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    dcp_req_tracker_if.slave            bus,
    output logic                        busy_o,
    output logic                        err_o
`ifdef DCP_TRACKER_STATS_EN
   ,output logic [31:0]                 stat_req_cnt_o,
    output logic [15:0]                 stat_err_cnt_o,
    output logic [`DCP_MSHRID_WIDTH:0]  stat_max_outst_o
`endif
);
    localparam int IDW = `DCP_MSHRID_WIDTH;

    typedef enum logic [1:0] {ST_FREE, ST_ISSUED, ST_DONE} ent_state_e;

    ent_state_e     r_state     [NUM_MSHR];
    ent_state_e     w_state_nxt [NUM_MSHR];
    paddr_t         r_ent_paddr [NUM_MSHR];
    size_t          r_ent_size  [NUM_MSHR];

    logic           r_out_val;
    req_type_t      r_out_type;
    paddr_t         r_out_paddr;
    size_t          r_out_size;
    homeid_t        r_out_homeid;
    write_mask_t    r_out_wmask;
    data_t          r_out_data;
    mshrid_t        r_out_mshrid;

    logic           r_cmp_val;
    mshrid_t        r_cmp_id;
    paddr_t         r_cmp_paddr;
    size_t          r_cmp_size;
    data_t          r_cmp_data;

    logic           r_err;
    logic           r_busy;

    logic           w_any_free;
    mshrid_t        w_alloc_id;
    logic           w_req_acc;
    logic           w_resp_acc;
    logic           w_cmp_hs;
    logic           w_resp_hit;
    paddr_t         w_hit_paddr;
    size_t          w_hit_size;
    logic           w_busy_nxt;

    // Lowest-index FREE entry wins: scan downward so the last assignment is the lowest.
    always_comb begin
        w_any_free = 1'b0;
        w_alloc_id = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (r_state[i] == ST_FREE) begin
                w_any_free = 1'b1;
                w_alloc_id = mshrid_t'(i);
            end
        end
    end

    assign w_req_acc  = bus.req_val  & bus.req_rdy;
    assign w_resp_acc = bus.resp_val & bus.resp_rdy;
    assign w_cmp_hs   = r_cmp_val    & bus.cmp_rdy;

    // Allocation, response and free always touch distinct entries in one cycle
    // (FREE, ISSUED and DONE respectively), so the updates never collide. A freed
    // entry only becomes allocatable once r_state shows FREE, i.e. a cycle later.
    always_comb begin
        w_resp_hit  = 1'b0;
        w_hit_paddr = '0;
        w_hit_size  = '0;
        w_busy_nxt  = 1'b0;
        for (int i = 0; i < NUM_MSHR; i++) begin
            w_state_nxt[i] = r_state[i];
            if (w_req_acc && (w_alloc_id == mshrid_t'(i))) begin
                w_state_nxt[i] = ST_ISSUED;
            end
            if (w_resp_acc && (bus.resp_mshrid == mshrid_t'(i)) && (r_state[i] == ST_ISSUED)) begin
                w_state_nxt[i] = ST_DONE;
                w_resp_hit     = 1'b1;
                w_hit_paddr    = r_ent_paddr[i];
                w_hit_size     = r_ent_size[i];
            end
            if (w_cmp_hs && (r_cmp_id == mshrid_t'(i))) begin
                w_state_nxt[i] = ST_FREE;
            end
            if (w_state_nxt[i] != ST_FREE) begin
                w_busy_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                r_state[i]     <= ST_FREE;
                r_ent_paddr[i] <= '0;
                r_ent_size[i]  <= '0;
            end
            r_out_val    <= 1'b0;
            r_out_type   <= '0;
            r_out_paddr  <= '0;
            r_out_size   <= '0;
            r_out_homeid <= '0;
            r_out_wmask  <= '0;
            r_out_data   <= '0;
            r_out_mshrid <= '0;
            r_cmp_val    <= 1'b0;
            r_cmp_id     <= '0;
            r_cmp_paddr  <= '0;
            r_cmp_size   <= '0;
            r_cmp_data   <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                r_state[i] <= w_state_nxt[i];
                if (w_req_acc && (w_alloc_id == mshrid_t'(i))) begin
                    r_ent_paddr[i] <= bus.req_paddr;
                    r_ent_size[i]  <= bus.req_size;
                end
            end

            if (w_req_acc) begin
                r_out_val    <= 1'b1;
                r_out_type   <= bus.req_type;
                r_out_paddr  <= bus.req_paddr;
                r_out_size   <= bus.req_size;
                r_out_homeid <= bus.req_homeid;
                r_out_wmask  <= bus.req_wmask;
                r_out_data   <= bus.req_data;
                r_out_mshrid <= w_alloc_id;
            end else if (bus.out_rdy) begin
                r_out_val    <= 1'b0;
            end

            // A new completion may load in the same cycle the held one is taken.
            if (w_resp_hit) begin
                r_cmp_val   <= 1'b1;
                r_cmp_id    <= bus.resp_mshrid;
                r_cmp_paddr <= w_hit_paddr;
                r_cmp_size  <= w_hit_size;
                r_cmp_data  <= bus.resp_data;
            end else if (w_cmp_hs) begin
                r_cmp_val   <= 1'b0;
            end

            r_err  <= w_resp_acc & ~w_resp_hit;
            r_busy <= w_busy_nxt;
        end
    end

    assign bus.req_rdy    = w_any_free & (~r_out_val | bus.out_rdy);
    assign bus.resp_rdy   = ~r_cmp_val | bus.cmp_rdy;

    assign bus.out_val    = r_out_val;
    assign bus.out_type   = r_out_type;
    assign bus.out_paddr  = r_out_paddr;
    assign bus.out_size   = r_out_size;
    assign bus.out_homeid = r_out_homeid;
    assign bus.out_wmask  = r_out_wmask;
    assign bus.out_data   = r_out_data;
    assign bus.out_mshrid = r_out_mshrid;

    assign bus.cmp_val    = r_cmp_val;
    assign bus.cmp_paddr  = r_cmp_paddr;
    assign bus.cmp_size   = r_cmp_size;
    assign bus.cmp_data   = r_cmp_data;

    assign busy_o = r_busy;
    assign err_o  = r_err;

`ifdef DCP_TRACKER_STATS_EN
    logic [31:0]    r_stat_req;
    logic [15:0]    r_stat_err;
    logic [IDW:0]   r_stat_max;
    logic [IDW:0]   w_outst_nxt;

    always_comb begin
        w_outst_nxt = '0;
        for (int i = 0; i < NUM_MSHR; i++) begin
            if (w_state_nxt[i] != ST_FREE) begin
                w_outst_nxt = w_outst_nxt + (IDW + 1)'(1);
            end
        end
    end

    // Counters saturate rather than wrap.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_stat_req <= '0;
            r_stat_err <= '0;
            r_stat_max <= '0;
        end else begin
            if (w_req_acc && (r_stat_req != '1)) begin
                r_stat_req <= r_stat_req + 32'd1;
            end
            if (w_resp_acc && !w_resp_hit && (r_stat_err != '1)) begin
                r_stat_err <= r_stat_err + 16'd1;
            end
            if (w_outst_nxt > r_stat_max) begin
                r_stat_max <= w_outst_nxt;
            end
        end
    end

    assign stat_req_cnt_o   = r_stat_req;
    assign stat_err_cnt_o   = r_stat_err;
    assign stat_max_outst_o = r_stat_max;
`endif

endmodule
